// File: rtl/dbg_bridge_host.sv
// dbg_bridge_host: initiator end of the UART debug-bridge byte protocol.
// It sends a four-byte header, then streams write payload or collects read data.
// It waits for the responder's 0x00 ack, and it reports unsolicited attention
// (0xAA) and sync (0x55) bytes.
//
// Ports:
//   AClkH, AResetH, AClkHEn      clock, sync active-high reset, clock enable
//   ASync1K                      1 kHz strobe driving the response timeout
//   AReqStart/Cmd/Addr/Len       transaction request, sampled in Idle only
//   AWrData/AWrReq/AWrAck        write payload handshake
//   ARdData/ARdNow               read data, registered one-cycle strobe
//   ASendData/ASendNow/ASendHasSpace   TX FIFO write side
//   ARecvData/ARecvNow           RX FIFO byte stream
//   ABusy/ADone/AErr/AErrCode    status; AErrCode held until the next start
//   AAttSeen/ASyncSeen           0xAA / 0x55 seen outside a read data phase
module dbg_bridge_host #(
  parameter int unsigned CTimeOut = 1000
) (
  input  logic        AClkH,
  input  logic        AResetH,
  input  logic        AClkHEn,
  input  logic        ASync1K,
  input  logic        AReqStart,
  input  logic [1:0]  AReqCmd,
  input  logic [11:0] AReqAddr,
  input  logic [15:0] AReqLen,
  input  logic [7:0]  AWrData,
  input  logic        AWrReq,
  output logic        AWrAck,
  output logic [7:0]  ARdData,
  output logic        ARdNow,
  output logic [7:0]  ASendData,
  output logic        ASendNow,
  input  logic        ASendHasSpace,
  input  logic [7:0]  ARecvData,
  input  logic        ARecvNow,
  output logic        ABusy,
  output logic        ADone,
  output logic        AErr,
  output logic [1:0]  AErrCode,
  output logic        AAttSeen,
  output logic        ASyncSeen
);

  typedef enum logic [9:0] {
    StIdle   = 10'b00_0000_0001,
    StHdr0   = 10'b00_0000_0010,
    StHdr1   = 10'b00_0000_0100,
    StHdr2   = 10'b00_0000_1000,
    StHdr3   = 10'b00_0001_0000,
    StWrData = 10'b00_0010_0000,
    StWrAck  = 10'b00_0100_0000,
    StRdAck  = 10'b00_1000_0000,
    StRdData = 10'b01_0000_0000,
    StDone   = 10'b10_0000_0000
  } stateT;

  localparam logic [9:0] TimeOutInit = 10'(CTimeOut);

  stateT       stateQ, stateD;
  logic [1:0]  cmdQ, cmdD;
  logic [11:0] addrQ, addrD;
  logic [15:0] lenQ, lenD;
  logic [9:0]  timerQ, timerD;
  logic [1:0]  errCodeQ, errCodeD;
  logic        errQ, rdNowQ, attQ, syncQ;
  logic [7:0]  rdDataQ;

  logic [3:0]  ctrlNib;
  logic        isRead, isAcked;
  logic        recvEvt, tickEvt, rxIsAtt, rxIsSync;
  logic        sendNow, wrAck, errSet, rdFwd, flagOk;
  logic [7:0]  sendData;

  // Strobes from outside only count on enabled cycles.
  assign recvEvt  = AClkHEn & ARecvNow;
  assign tickEvt  = AClkHEn & ASync1K;
  assign rxIsAtt  = (ARecvData == 8'hAA);
  assign rxIsSync = (ARecvData == 8'h55);
  assign isRead   = (cmdQ == 2'd2);
  assign isAcked  = (cmdQ == 2'd0);

  always_comb begin
    unique case (cmdQ)
      2'd0:    ctrlNib = 4'hC;
      2'd1:    ctrlNib = 4'hD;
      default: ctrlNib = 4'h8;
    endcase
  end

  always_comb begin
    stateD   = stateQ;
    cmdD     = cmdQ;
    addrD    = addrQ;
    lenD     = lenQ;
    timerD   = timerQ;
    errCodeD = errCodeQ;
    sendNow  = 1'b0;
    sendData = 8'h00;
    wrAck    = 1'b0;
    errSet   = 1'b0;
    rdFwd    = 1'b0;
    flagOk   = 1'b1;

    unique case (stateQ)
      StIdle: begin
        if (AReqStart) begin
          errCodeD = 2'd0;
          if (AReqCmd == 2'd3) begin
            errSet   = 1'b1;
            errCodeD = 2'd3;
          end else begin
            cmdD   = AReqCmd;
            addrD  = AReqAddr;
            lenD   = AReqLen;
            stateD = StHdr0;
          end
        end
      end

      StHdr0: begin
        sendData = {ctrlNib, addrQ[11:8]};
        if (ASendHasSpace) begin
          sendNow = 1'b1;
          stateD  = StHdr1;
        end
      end

      StHdr1: begin
        sendData = addrQ[7:0];
        if (ASendHasSpace) begin
          sendNow = 1'b1;
          stateD  = StHdr2;
        end
      end

      StHdr2: begin
        sendData = lenQ[7:0];
        if (ASendHasSpace) begin
          sendNow = 1'b1;
          stateD  = StHdr3;
        end
      end

      StHdr3: begin
        sendData = lenQ[15:8];
        if (ASendHasSpace) begin
          sendNow = 1'b1;
          timerD  = TimeOutInit;
          if (isRead) begin
            stateD = StRdAck;
          end else if (lenQ == 16'd0) begin
            stateD = isAcked ? StWrAck : StDone;
          end else begin
            stateD = StWrData;
          end
        end
      end

      StWrData: begin
        sendData = AWrData;
        if (AWrReq && ASendHasSpace) begin
          sendNow = 1'b1;
          wrAck   = 1'b1;
          lenD    = lenQ - 16'd1;
          if (lenQ == 16'd1) begin
            timerD = TimeOutInit;
            stateD = isAcked ? StWrAck : StDone;
          end
        end
      end

      StWrAck, StRdAck: begin
        if (recvEvt) begin
          timerD = TimeOutInit;
          if (ARecvData == 8'h00) begin
            if (stateQ == StWrAck) begin
              stateD = StDone;
            end else begin
              stateD = (lenQ == 16'd0) ? StDone : StRdData;
            end
          end else if (!rxIsAtt && !rxIsSync) begin
            errSet   = 1'b1;
            errCodeD = 2'd2;
            stateD   = StIdle;
          end
        end else if (tickEvt) begin
          // Expire on the tick that would take the count to zero.
          if (timerQ <= 10'd1) begin
            timerD   = 10'd0;
            errSet   = 1'b1;
            errCodeD = 2'd1;
            stateD   = StIdle;
          end else begin
            timerD = timerQ - 10'd1;
          end
        end
      end

      StRdData: begin
        // Payload bytes are raw data: no attention/sync interpretation.
        flagOk = 1'b0;
        if (recvEvt) begin
          rdFwd  = 1'b1;
          timerD = TimeOutInit;
          lenD   = lenQ - 16'd1;
          if (lenQ == 16'd1) begin
            stateD = StDone;
          end
        end else if (tickEvt) begin
          if (timerQ <= 10'd1) begin
            timerD   = 10'd0;
            errSet   = 1'b1;
            errCodeD = 2'd1;
            stateD   = StIdle;
          end else begin
            timerD = timerQ - 10'd1;
          end
        end
      end

      StDone: begin
        stateD = StIdle;
      end

      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      stateQ   <= StIdle;
      cmdQ     <= 2'd0;
      addrQ    <= 12'd0;
      lenQ     <= 16'd0;
      timerQ   <= 10'd0;
      errCodeQ <= 2'd0;
      errQ     <= 1'b0;
      rdNowQ   <= 1'b0;
      rdDataQ  <= 8'h00;
      attQ     <= 1'b0;
      syncQ    <= 1'b0;
    end else begin
      // Pulse registers update every clock so each pulse lasts exactly one AClkH cycle.
      errQ   <= AClkHEn & errSet;
      rdNowQ <= rdFwd;
      attQ   <= recvEvt & flagOk & rxIsAtt;
      syncQ  <= recvEvt & flagOk & rxIsSync;
      if (AClkHEn) begin
        stateQ   <= stateD;
        cmdQ     <= cmdD;
        addrQ    <= addrD;
        lenQ     <= lenD;
        timerQ   <= timerD;
        errCodeQ <= errCodeD;
        if (rdFwd) begin
          rdDataQ <= ARecvData;
        end
      end
    end
  end

  assign ASendNow  = sendNow & AClkHEn;
  assign ASendData = sendData;
  assign AWrAck    = wrAck & AClkHEn;
  assign ABusy     = (stateQ != StIdle);
  assign ADone     = (stateQ == StDone) & AClkHEn;
  assign AErr      = errQ;
  assign AErrCode  = errCodeQ;
  assign ARdNow    = rdNowQ;
  assign ARdData   = rdDataQ;
  assign AAttSeen  = attQ;
  assign ASyncSeen = syncQ;

endmodule

// File: tb/tb_dbg_bridge_host.sv
// Directed bench for dbg_bridge_host: each task runs one scenario and checks inline.
module tb_dbg_bridge_host;

  logic        AClkH = 1'b0;
  logic        AResetH, AClkHEn, ASync1K, AReqStart, AWrReq, ASendHasSpace, ARecvNow;
  logic [1:0]  AReqCmd;
  logic [11:0] AReqAddr;
  logic [15:0] AReqLen;
  logic [7:0]  AWrData, ARecvData;
  logic        AWrAck, ARdNow, ASendNow, ABusy, ADone, AErr, AAttSeen, ASyncSeen;
  logic [7:0]  ARdData, ASendData;
  logic [1:0]  AErrCode;

  always #5 AClkH = ~AClkH;

  dbg_bridge_host #(.CTimeOut(1000)) dut (
    .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn), .ASync1K(ASync1K),
    .AReqStart(AReqStart), .AReqCmd(AReqCmd), .AReqAddr(AReqAddr), .AReqLen(AReqLen),
    .AWrData(AWrData), .AWrReq(AWrReq), .AWrAck(AWrAck),
    .ARdData(ARdData), .ARdNow(ARdNow),
    .ASendData(ASendData), .ASendNow(ASendNow), .ASendHasSpace(ASendHasSpace),
    .ARecvData(ARecvData), .ARecvNow(ARecvNow),
    .ABusy(ABusy), .ADone(ADone), .AErr(AErr), .AErrCode(AErrCode),
    .AAttSeen(AAttSeen), .ASyncSeen(ASyncSeen)
  );

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] txQ[$];
  logic [7:0] rdQ[$];
  int doneCnt = 0, errCnt = 0, attCnt = 0, syncCnt = 0;

  // Observer: outputs are stable at the falling edge.
  always @(negedge AClkH) begin
    if (ASendNow)  txQ.push_back(ASendData);
    if (ARdNow)    rdQ.push_back(ARdData);
    if (ADone)     doneCnt++;
    if (AErr)      errCnt++;
    if (AAttSeen)  attCnt++;
    if (ASyncSeen) syncCnt++;
  end

  task automatic tick();
    @(posedge AClkH);
    #1;
  endtask

  task automatic clearObs();
    txQ.delete();
    rdQ.delete();
    doneCnt = 0;
    errCnt  = 0;
    attCnt  = 0;
    syncCnt = 0;
  endtask

  task automatic startReq(input logic [1:0] cmd, input logic [11:0] addr, input logic [15:0] len);
    AReqCmd   = cmd;
    AReqAddr  = addr;
    AReqLen   = len;
    AReqStart = 1'b1;
    tick();
    AReqStart = 1'b0;
  endtask

  task automatic sendRx(input logic [7:0] b);
    ARecvData = b;
    ARecvNow  = 1'b1;
    tick();
    ARecvNow  = 1'b0;
  endtask

  task automatic waitTx(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (txQ.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic waitIdle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge AClkH);
      if (!ABusy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) tick();
  endtask

  task automatic writePayload(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              output bit ok);
    int  idx;
    bit  took;
    idx     = 0;
    AWrData = b0;
    AWrReq  = 1'b1;
    for (int c = 0; c < 100 && idx < n; c++) begin
      @(negedge AClkH);
      took = AWrAck;
      tick();
      if (took) begin
        idx++;
        AWrData = (idx == 1) ? b1 : 8'h00;
      end
    end
    AWrReq = 1'b0;
    ok = (idx == n);
  endtask

  task automatic test_reset();
    logic [25:0] outs;
    AResetH = 1'b1; AClkHEn = 1'b1; ASync1K = 1'b0; AReqStart = 1'b0; AReqCmd = 2'd0;
    AReqAddr = 12'd0; AReqLen = 16'd0; AWrData = 8'd0; AWrReq = 1'b0;
    ASendHasSpace = 1'b1; ARecvData = 8'd0; ARecvNow = 1'b0;
    repeat (3) tick();
    outs = {ABusy, ADone, AErr, AErrCode, ARdNow, ARdData, ASendNow, ASendData, AWrAck,
            AAttSeen, ASyncSeen};
    testsRun++;
    if (outs !== 26'd0) begin
      testsFailed++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    AResetH = 1'b0;
    repeat (2) tick();
    testsRun++;
    if (ABusy !== 1'b0) begin
      testsFailed++;
      $display("FAIL reset_idle: ABusy got %b want 0", ABusy);
    end
  endtask

  task automatic test_write_acked();
    logic [7:0] exp[6] = '{8'hC1, 8'h23, 8'h02, 8'h00, 8'h11, 8'h22};
    logic [7:0] got;
    bit ok;
    clearObs();
    startReq(2'd0, 12'h123, 16'd2);
    writePayload(2, 8'h11, 8'h22, ok);
    testsRun++;
    if (ok !== 1'b1) begin
      testsFailed++;
      $display("FAIL wr_payload_taken: got %b want 1", ok);
    end
    tick();
    sendRx(8'h00);
    waitIdle(50, ok);
    testsRun++;
    if (txQ.size() !== 6) begin
      testsFailed++;
      $display("FAIL wr_tx_count: got %0d want 6", txQ.size());
    end
    for (int i = 0; i < 6; i++) begin
      got = (i < txQ.size()) ? txQ[i] : 8'hxx;
      testsRun++;
      if (got !== exp[i]) begin
        testsFailed++;
        $display("FAIL wr_tx_byte%0d: got %h want %h", i, got, exp[i]);
      end
    end
    testsRun++;
    if (doneCnt !== 1 || errCnt !== 0) begin
      testsFailed++;
      $display("FAIL wr_done: done %0d err %0d want 1 0", doneCnt, errCnt);
    end
  endtask

  task automatic test_read();
    logic [7:0] expTx[4] = '{8'h87, 8'h00, 8'h03, 8'h00};
    logic [7:0] expRd[3] = '{8'hAA, 8'h55, 8'h07};
    logic [7:0] got;
    bit ok;
    clearObs();
    startReq(2'd2, 12'h700, 16'd3);
    waitTx(4, ok);
    sendRx(8'h00);
    sendRx(8'hAA);
    sendRx(8'h55);
    sendRx(8'h07);
    waitIdle(50, ok);
    for (int i = 0; i < 4; i++) begin
      got = (i < txQ.size()) ? txQ[i] : 8'hxx;
      testsRun++;
      if (got !== expTx[i]) begin
        testsFailed++;
        $display("FAIL rd_tx_byte%0d: got %h want %h", i, got, expTx[i]);
      end
    end
    testsRun++;
    if (rdQ.size() !== 3) begin
      testsFailed++;
      $display("FAIL rd_count: got %0d want 3", rdQ.size());
    end
    for (int i = 0; i < 3; i++) begin
      got = (i < rdQ.size()) ? rdQ[i] : 8'hxx;
      testsRun++;
      if (got !== expRd[i]) begin
        testsFailed++;
        $display("FAIL rd_data%0d: got %h want %h", i, got, expRd[i]);
      end
    end
    testsRun++;
    if (doneCnt !== 1 || attCnt !== 0 || syncCnt !== 0 || txQ.size() !== 4) begin
      testsFailed++;
      $display("FAIL rd_status: done %0d att %0d sync %0d tx %0d want 1 0 0 4",
               doneCnt, attCnt, syncCnt, txQ.size());
    end
  endtask

  task automatic test_posted_backpressure();
    logic [7:0] exp[4] = '{8'hDA, 8'hBC, 8'h00, 8'h00};
    logic [7:0] got;
    bit ok;
    clearObs();
    ASendHasSpace = 1'b0;
    startReq(2'd1, 12'hABC, 16'd0);
    repeat (5) tick();
    testsRun++;
    if (txQ.size() !== 0 || ABusy !== 1'b1) begin
      testsFailed++;
      $display("FAIL posted_hold: tx %0d busy %b want 0 1", txQ.size(), ABusy);
    end
    ASendHasSpace = 1'b1;
    waitIdle(50, ok);
    testsRun++;
    if (ok !== 1'b1 || txQ.size() !== 4 || doneCnt !== 1) begin
      testsFailed++;
      $display("FAIL posted_done: idle %b tx %0d done %0d want 1 4 1", ok, txQ.size(), doneCnt);
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < txQ.size()) ? txQ[i] : 8'hxx;
      testsRun++;
      if (got !== exp[i]) begin
        testsFailed++;
        $display("FAIL posted_tx_byte%0d: got %h want %h", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int  pulses;
    bit  ok;
    bit  idle;
    clearObs();
    startReq(2'd2, 12'h055, 16'd1);
    waitTx(4, ok);
    pulses = 0;
    idle   = 1'b0;
    for (int c = 0; c < 12000; c++) begin
      ASync1K = (c % 10 == 9);
      if (ASync1K) pulses++;
      tick();
      ASync1K = 1'b0;
      if (!ABusy) begin
        idle = 1'b1;
        break;
      end
    end
    repeat (3) tick();
    testsRun++;
    if (idle !== 1'b1 || pulses !== 1000) begin
      testsFailed++;
      $display("FAIL timeout_ticks: idle %b ticks %0d want 1 1000", idle, pulses);
    end
    testsRun++;
    if (errCnt !== 1 || AErrCode !== 2'd1 || doneCnt !== 0) begin
      testsFailed++;
      $display("FAIL timeout_err: err %0d code %0d done %0d want 1 1 0",
               errCnt, AErrCode, doneCnt);
    end
  endtask

  task automatic test_bad_ack();
    bit ok;
    clearObs();
    startReq(2'd0, 12'h010, 16'd1);
    writePayload(1, 8'h5A, 8'h00, ok);
    tick();
    sendRx(8'hAA);
    sendRx(8'h42);
    waitIdle(50, ok);
    testsRun++;
    if (attCnt !== 1 || errCnt !== 1 || doneCnt !== 0) begin
      testsFailed++;
      $display("FAIL badack_pulses: att %0d err %0d done %0d want 1 1 0",
               attCnt, errCnt, doneCnt);
    end
    testsRun++;
    if (AErrCode !== 2'd2 || txQ.size() !== 5) begin
      testsFailed++;
      $display("FAIL badack_code: code %0d tx %0d want 2 5", AErrCode, txQ.size());
    end
  endtask

  task automatic test_idle_flags_and_reserved();
    clearObs();
    sendRx(8'h55);
    sendRx(8'hAA);
    sendRx(8'h13);
    repeat (2) tick();
    testsRun++;
    if (syncCnt !== 1 || attCnt !== 1 || ABusy !== 1'b0) begin
      testsFailed++;
      $display("FAIL idle_flags: sync %0d att %0d busy %b want 1 1 0", syncCnt, attCnt, ABusy);
    end
    clearObs();
    startReq(2'd3, 12'h001, 16'd4);
    repeat (3) tick();
    testsRun++;
    if (errCnt !== 1 || AErrCode !== 2'd3 || ABusy !== 1'b0 || txQ.size() !== 0) begin
      testsFailed++;
      $display("FAIL reserved_cmd: err %0d code %0d busy %b tx %0d want 1 3 0 0",
               errCnt, AErrCode, ABusy, txQ.size());
    end
  endtask

  task automatic test_clock_enable();
    clearObs();
    AClkHEn = 1'b0;
    startReq(2'd1, 12'h000, 16'd0);
    repeat (3) tick();
    testsRun++;
    if (ABusy !== 1'b0 || txQ.size() !== 0) begin
      testsFailed++;
      $display("FAIL clken_hold: busy %b tx %0d want 0 0", ABusy, txQ.size());
    end
    AClkHEn = 1'b1;
    repeat (2) tick();
    testsRun++;
    if (ABusy !== 1'b0) begin
      testsFailed++;
      $display("FAIL clken_resume: busy %b want 0", ABusy);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [25:0] outs;
    bit ok;
    clearObs();
    startReq(2'd2, 12'h300, 16'd3);
    waitTx(4, ok);
    sendRx(8'h00);
    sendRx(8'h11);
    AResetH = 1'b1;
    tick();
    outs = {ABusy, ADone, AErr, AErrCode, ARdNow, ARdData, ASendNow, ASendData, AWrAck,
            AAttSeen, ASyncSeen};
    AResetH = 1'b0;
    testsRun++;
    if (outs !== 26'd0) begin
      testsFailed++;
      $display("FAIL midreset_outputs: got %h want 0", outs);
    end
    repeat (3) tick();
    testsRun++;
    if (doneCnt !== 0 || errCnt !== 0) begin
      testsFailed++;
      $display("FAIL midreset_silent: done %0d err %0d want 0 0", doneCnt, errCnt);
    end
    clearObs();
    startReq(2'd2, 12'h0FF, 16'd1);
    waitTx(4, ok);
    sendRx(8'h00);
    sendRx(8'h3C);
    waitIdle(50, ok);
    testsRun++;
    if (txQ.size() !== 4 || txQ[0] !== 8'h80 || txQ[1] !== 8'hFF || txQ[2] !== 8'h01) begin
      testsFailed++;
      $display("FAIL postreset_hdr: tx count %0d want 4 with 80 FF 01 00", txQ.size());
    end
    testsRun++;
    if (rdQ.size() !== 1 || rdQ[0] !== 8'h3C || doneCnt !== 1) begin
      testsFailed++;
      $display("FAIL postreset_read: rd count %0d done %0d want 1 byte 3C, 1 done",
               rdQ.size(), doneCnt);
    end
  endtask

  initial begin
    test_reset();
    test_write_acked();
    test_read();
    test_posted_backpressure();
    test_timeout();
    test_bad_ack();
    test_idle_flags_and_reserved();
    test_clock_enable();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
